// File: rtl/scroll_layer_draw.sv
// scroll_layer_draw: a horizontally scrolling texture band drawn into a
// raster. A small FSM follows the game state and advances the scroll offset
// once per frame. The pixel path turns (xx, yy) into a texture ROM address.
// One clock later it merges the ROM word into rgb / is_empty.
module scroll_layer_draw #(
    parameter int TEX_W        = 2400,
    parameter int TEX_H        = 27,
    parameter int BASE_Y       = 100,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int ADDR_W       = 16,
    parameter int SPEED_W      = 4,
    parameter int MODE         = 0,
    parameter int MIN_SPEED    = 1,
    parameter int SPEED_MAX    = 15,
    parameter int ACCEL_FRAMES = 600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         gamestate,
    input  logic               frame_tick,
    input  logic [SPEED_W-1:0] speed,
    input  logic [9:0]         xx,
    input  logic [8:0]         yy,
    output logic [ADDR_W-1:0]  tex_addr,
    input  logic [15:0]        tex_data,
    output logic [11:0]        rgb,
    output logic               is_empty,
    output logic [11:0]        scroll_pos,
    output logic [SPEED_W-1:0] cur_speed,
    output logic [7:0]         wrap_count
);

    localparam int FC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [12:0]        TEX_W13  = 13'(TEX_W);
    localparam logic [SPEED_W-1:0] MIN_SPD  = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] MAX_SPD  = SPEED_W'(SPEED_MAX);
    localparam logic [SPEED_W-1:0] SPD_RST  = (MODE == 1) ? MIN_SPD : '0;
    localparam logic [FC_W-1:0]    FC_LAST  = FC_W'(ACCEL_FRAMES - 1);
    localparam logic [9:0]         Y_LO     = 10'(BASE_Y);
    localparam logic [9:0]         Y_HI     = 10'(BASE_Y + TEX_H - 1);

    // Reject parameter sets the datapath cannot represent.
    if (longint'(TEX_W) * longint'(TEX_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("scroll_layer_draw: TEX_W*TEX_H exceeds 2**ADDR_W");
    end
    if (SPEED_MAX >= TEX_W) begin : g_bad_speed
        $error("scroll_layer_draw: SPEED_MAX must be below TEX_W");
    end
    if (SCREEN_W > TEX_W) begin : g_bad_screen
        $error("scroll_layer_draw: SCREEN_W must not exceed TEX_W");
    end
    if (TEX_W > 4096 || ADDR_W > 32 || SPEED_W > 12) begin : g_bad_width
        $error("scroll_layer_draw: TEX_W, ADDR_W or SPEED_W out of range");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("scroll_layer_draw: MODE must be 0 or 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

    state_t             state_q, state_d;
    logic [11:0]        scroll_q, scroll_d;
    logic [7:0]         wrap_q, wrap_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;
    logic               band_q;

    logic [12:0] sum_w;
    logic [9:0]  y_w;
    logic [9:0]  row_w;
    logic [12:0] col_sum_w;
    logic [12:0] col_w;
    logic [31:0] addr_full_w;
    logic        in_band_w;

    // Next FSM state: the game state is re-read every clock.
    always_comb begin
        state_d = S_IDLE;
        case (gamestate)
            2'b01:   state_d = S_RUN;
            2'b10:   state_d = S_FROZEN;
            default: state_d = S_IDLE;
        endcase
    end

    // Scroll, wrap and speed updates for the current FSM state.
    always_comb begin
        scroll_d = scroll_q;
        wrap_d   = wrap_q;
        speed_d  = speed_q;
        fcnt_d   = fcnt_q;
        sum_w    = 13'(scroll_q) + 13'(speed_q);
        case (state_q)
            S_IDLE: begin
                scroll_d = '0;
                wrap_d   = '0;
                fcnt_d   = '0;
                speed_d  = (MODE == 1) ? MIN_SPD : speed;
            end
            S_RUN: begin
                if (frame_tick) begin
                    // The advance always uses the speed held before this tick.
                    if (sum_w >= TEX_W13) begin
                        scroll_d = 12'(sum_w - TEX_W13);
                        if (wrap_q != 8'hFF) begin
                            wrap_d = wrap_q + 8'd1;
                        end
                    end else begin
                        scroll_d = sum_w[11:0];
                    end
                    if (MODE == 1) begin
                        if (fcnt_q == FC_LAST) begin
                            fcnt_d = '0;
                            if (speed_q < MAX_SPD) begin
                                speed_d = speed_q + 1'b1;
                            end
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end else begin
                        speed_d = speed;
                    end
                end
            end
            default: ;
        endcase
    end

    // State registers; rst clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            scroll_q <= '0;
            wrap_q   <= '0;
            speed_q  <= SPD_RST;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            scroll_q <= scroll_d;
            wrap_q   <= wrap_d;
            speed_q  <= speed_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Pixel stage 0: flip to y-up, test band membership and form the ROM address.
    always_comb begin
        y_w         = 10'(SCREEN_H) - {1'b0, yy};
        in_band_w   = (y_w >= Y_LO) && (y_w <= Y_HI) && ({1'b0, xx} < 11'(SCREEN_W));
        col_sum_w   = 13'(scroll_q) + 13'(xx);
        col_w       = (col_sum_w >= TEX_W13) ? (col_sum_w - TEX_W13) : col_sum_w;
        row_w       = Y_HI - y_w;
        addr_full_w = 32'(row_w) * 32'(TEX_W) + 32'(col_w);
        tex_addr    = in_band_w ? addr_full_w[ADDR_W-1:0] : '0;
    end

    // Pixel stage 1: band flag delayed to line up with the ROM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_q <= 1'b0;
        end else begin
            band_q <= in_band_w;
        end
    end

    // Only fully opaque texels inside the band are drawn.
    always_comb begin
        rgb      = 12'hFFF;
        is_empty = 1'b1;
        if (band_q && tex_data[3:0] == 4'hF) begin
            rgb      = tex_data[15:4];
            is_empty = 1'b0;
        end
    end

    assign scroll_pos = scroll_q;
    assign cur_speed  = speed_q;
    assign wrap_count = wrap_q;

endmodule
